// File: rtl/dout_display_if.sv
// CPU data-output bus: the CPU presents Dout qualified by the level Dval, and
// the display end reports Busy while a conversion is in flight.
interface dout_display_if;
    logic [7:0] Dout;
    logic       Dval;
    logic       Busy;

    modport master (output Dout, output Dval, input  Busy);
    modport slave  (input  Dout, input  Dval, output Busy);
endinterface

// File: rtl/dout_display.sv
// Display end of the CPU data-output bus: converts each accepted word to sign plus
// three BCD digits (sequential double-dabble) and scans a 4-digit active-low 7-seg.
module dout_display #(
    parameter int SCAN_DIV = 50000,
    parameter bit SIGNED   = 1'b1
) (
    input  logic           Clock,
    input  logic           Reset,
    dout_display_if.slave  bus,
    output logic [6:0]     Seg,
    output logic [3:0]     An
);
    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_data, r_pend_data, r_mag;
    logic        r_pend_vld, r_neg;
    logic [11:0] r_bcd, w_bcd_adj;
    logic [3:0]  r_bitcnt;
    logic [11:0] r_disp_bcd;
    logic        r_disp_neg;
    logic        w_take_pend, w_take_dval, w_capture_pend;
    logic [CNT_W-1:0] r_scan_cnt;
    logic [1:0]  r_idx;
    logic [3:0]  w_digit [4];

    function automatic logic [11:0] dabble_adj(input logic [11:0] b);
        logic [11:0] r;
        for (int i = 0; i < 3; i++)
            r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
        return r;
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            4'hA:    return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    always_ff @(posedge Clock) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_take_pend    = 1'b0;
        w_take_dval    = 1'b0;
        // Any Dval not consumed directly by an idle engine lands in the pending slot.
        w_capture_pend = bus.Dval && ((r_state != S_IDLE) || r_pend_vld);
        case (r_state)
            S_IDLE: begin
                if (r_pend_vld) begin
                    w_take_pend = 1'b1;
                    w_state_nxt = S_LOAD;
                end else if (bus.Dval) begin
                    w_take_dval = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD:   w_state_nxt = S_SHIFT;
            S_SHIFT:  if (r_bitcnt == 4'd1) w_state_nxt = S_COMMIT;
            S_COMMIT: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.Busy  = (r_state != S_IDLE);
    assign w_bcd_adj = dabble_adj(r_bcd);

    always_ff @(posedge Clock) begin
        if (Reset)               r_pend_vld <= 1'b0;
        else if (w_capture_pend) r_pend_vld <= 1'b1;
        else if (w_take_pend)    r_pend_vld <= 1'b0;
    end

    always_ff @(posedge Clock) begin
        if (w_capture_pend) r_pend_data <= bus.Dout;
        if (w_take_pend)      r_data <= r_pend_data;
        else if (w_take_dval) r_data <= bus.Dout;
        if (r_state == S_LOAD) begin
            r_neg    <= SIGNED && r_data[7];
            r_mag    <= (SIGNED && r_data[7]) ? (~r_data + 8'd1) : r_data;
            r_bcd    <= '0;
            r_bitcnt <= 4'd8;
        end else if (r_state == S_SHIFT) begin
            {r_bcd, r_mag} <= {w_bcd_adj[10:0], r_mag, 1'b0};
            r_bitcnt       <= r_bitcnt - 4'd1;
        end
    end

    // Display registers move only here, so the scan never shows a half-converted value.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_disp_bcd <= '0;
            r_disp_neg <= 1'b0;
        end else if (r_state == S_COMMIT) begin
            r_disp_bcd <= r_bcd;
            r_disp_neg <= r_neg;
        end
    end

    always_comb begin
        w_digit[0] = r_disp_bcd[3:0];
        w_digit[1] = ((r_disp_bcd[11:8] == 4'd0) && (r_disp_bcd[7:4] == 4'd0))
                     ? DIG_BLANK : r_disp_bcd[7:4];
        w_digit[2] = (r_disp_bcd[11:8] == 4'd0) ? DIG_BLANK : r_disp_bcd[11:8];
        w_digit[3] = r_disp_neg ? DIG_MINUS : DIG_BLANK;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_scan_cnt <= '0;
            r_idx      <= 2'd0;
            An         <= 4'hF;
            Seg        <= 7'h7F;
        end else begin
            An  <= ~(4'b0001 << r_idx);
            Seg <= seg_code(w_digit[r_idx]);
            if (r_scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
                r_scan_cnt <= '0;
                r_idx      <= r_idx + 2'd1;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dout_display.sv
// Randomised and directed bench for dout_display: a signed and an unsigned instance
// share stimulus and are compared every cycle against a transaction-level model.
module tb_dout_display;
    localparam int SCAN_DIV = 4;
    localparam logic [6:0] CODES [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg_s, seg_u;
    logic [3:0] an_s, an_u;

    dout_display_if bus_s ();
    dout_display_if bus_u ();

    dout_display #(.SCAN_DIV(SCAN_DIV), .SIGNED(1'b1)) dut_s (
        .Clock(clk), .Reset(rst), .bus(bus_s), .Seg(seg_s), .An(an_s));
    dout_display #(.SCAN_DIV(SCAN_DIV), .SIGNED(1'b0)) dut_u (
        .Clock(clk), .Reset(rst), .bus(bus_u), .Seg(seg_u), .An(an_u));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected segment pattern for one display position showing word w.
    function automatic logic [6:0] seg_of(input logic [7:0] w, input bit sgn, input int pos);
        int v, mag, h, t, o;
        v   = sgn ? int'($signed(w)) : int'(w);
        mag = (v < 0) ? -v : v;
        h   = mag / 100;
        t   = (mag / 10) % 10;
        o   = mag % 10;
        case (pos)
            3:       return (v < 0) ? 7'h3F : 7'h7F;
            2:       return (h == 0) ? 7'h7F : CODES[h];
            1:       return (h == 0 && t == 0) ? 7'h7F : CODES[t];
            default: return CODES[o];
        endcase
    endfunction

    // Transaction model: a conversion occupies 10 cycles and publishes at the last one.
    int         m_rem = 0;
    int         m_tick = 0;
    logic [7:0] m_cur = 8'd0, m_disp = 8'd0, m_pend = 8'd0;
    bit         m_pend_v = 1'b0;
    logic [3:0] m_an = 4'hF;
    logic [6:0] m_seg_s = 7'h7F, m_seg_u = 7'h7F;

    always @(posedge clk) begin
        int idx;
        if (rst) begin
            m_rem = 0; m_tick = 0; m_pend_v = 1'b0; m_disp = 8'd0;
            m_an = 4'hF; m_seg_s = 7'h7F; m_seg_u = 7'h7F;
        end else begin
            idx     = (m_tick / SCAN_DIV) % 4;
            m_an    = ~(4'b0001 << idx);
            m_seg_s = seg_of(m_disp, 1'b1, idx);
            m_seg_u = seg_of(m_disp, 1'b0, idx);
            m_tick++;
            if (m_rem == 0) begin
                if (m_pend_v) begin
                    m_cur = m_pend; m_pend_v = 1'b0; m_rem = 10;
                    if (bus_s.Dval) begin m_pend = bus_s.Dout; m_pend_v = 1'b1; end
                end else if (bus_s.Dval) begin
                    m_cur = bus_s.Dout; m_rem = 10;
                end
            end else begin
                if (bus_s.Dval) begin m_pend = bus_s.Dout; m_pend_v = 1'b1; end
                m_rem--;
                if (m_rem == 0) m_disp = m_cur;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_s", 32'(bus_s.Busy), 32'(m_rem != 0));
            chk("busy_u", 32'(bus_u.Busy), 32'(m_rem != 0));
            chk("an_s",   32'(an_s),  32'(m_an));
            chk("an_u",   32'(an_u),  32'(m_an));
            chk("seg_s",  32'(seg_s), 32'(m_seg_s));
            chk("seg_u",  32'(seg_u), 32'(m_seg_u));
        end
    end

    task automatic drive(input bit r, input bit v, input logic [7:0] d);
        rst = r;
        bus_s.Dval = v; bus_s.Dout = d;
        bus_u.Dval = v; bus_u.Dout = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic pulse(input logic [7:0] d);
        drive(1'b0, 1'b1, d);
    endtask

    initial begin
        drive(1'b1, 1'b0, 8'd0);
        chk_en = 1'b1;
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b1, 1'b0, 8'd0);
        idle(4 * SCAN_DIV * 2);
        pulse(8'd42);           idle(24);
        pulse(8'h80);           idle(24);
        pulse(8'hFF);           idle(24);
        pulse(8'd5);  idle(2);
        pulse(8'd7);  idle(2);
        pulse(8'd9);            idle(30);
        pulse(8'd200); idle(1);
        pulse(8'd33);  idle(3);
        drive(1'b1, 1'b0, 8'd0);
        idle(24);
        for (int i = 0; i < 44; i++) drive(1'b0, 1'b1, 8'd100);
        idle(24);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0)
                drive(1'b1, 1'($urandom), 8'($urandom));
            else if ($urandom_range(0, 99) < 3)
                for (int j = 0; j < 15; j++) drive(1'b0, 1'b1, 8'($urandom));
            else
                drive(1'b0, ($urandom_range(0, 9) == 0), 8'($urandom));
        end
        idle(24);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
